// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - event handshake bundle between the arbiter and its consumer
//
// Purpose: carries one button event at a time over a valid/ready handshake.
// Signals:
//   evt_valid  arbiter -> consumer  an event is being offered
//   evt_id     arbiter -> consumer  index of the offered button (stable while evt_valid=1)
//   evt_ready  consumer -> arbiter  consumer accepts the offered event
// Modports:
//   master  the arbiter side (drives evt_valid/evt_id)
//   slave   the consumer side (drives evt_ready)
interface button_event_arbiter_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - queues per-button press events and serves them round-robin
//
// Purpose: takes one-cycle press pulses from the debounce bank, keeps one pending
// event per button with a per-button lockout window, and hands button IDs one at a
// time to a single consumer.
// Ports:
//   clk        system clock, rising edge
//   clear      asynchronous active-high reset
//   btn_pulse  one-cycle press pulses, bit i = button i
//   evt        handshake bundle (master side): evt_valid, evt_id out; evt_ready in
//   pending    registered pending flags, one per button
//   overflow   sticky per-button flag: a press arrived while its event was still pending
module button_event_arbiter #(
  parameter int N_BTN          = 4,
  parameter int ID_W           = 2,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [N_BTN-1:0]      btn_pulse,
  button_event_arbiter_if.master evt,
  output logic [N_BTN-1:0]      pending,
  output logic [N_BTN-1:0]      overflow
);

  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES);
  localparam logic [ID_W-1:0]  GRANT_INIT = ID_W'(N_BTN - 1);

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ID_W-1:0]  evt_id_q;
  logic [ID_W-1:0]  id_next;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_next;
  logic             handshake;

  logic [CNT_W-1:0] lock_cnt [N_BTN];
  logic [N_BTN-1:0] pend_next;
  logic [N_BTN-1:0] ovf_next;
  logic [N_BTN-1:0] reload;
  logic [N_BTN-1:0] clr_hit;

  logic             sel_found;
  logic [ID_W-1:0]  sel_idx;

  assign evt.evt_valid = (state == S_OFFER);
  assign evt.evt_id    = evt_id_q;

  // Round-robin search: first pending button after last_grant, wrapping modulo
  // N_BTN. The modulo keeps the search inside 0..N_BTN-1 even when ID_W leaves
  // spare encodings.
  always_comb begin
    int target;
    sel_found = 1'b0;
    sel_idx   = '0;
    target    = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      target = (int'(last_grant) + k) % N_BTN;
      for (int b = 0; b < N_BTN; b++) begin
        if (!sel_found && (b == target) && pending[b]) begin
          sel_found = 1'b1;
          sel_idx   = ID_W'(b);
        end
      end
    end
  end

  // Arbiter next-state logic. evt_id is captured once on entry to OFFER so
  // later presses cannot disturb an event that is already on offer.
  always_comb begin
    state_next = state;
    id_next    = evt_id_q;
    grant_next = last_grant;
    handshake  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          state_next = S_OFFER;
          id_next    = sel_idx;
        end
      end
      S_OFFER: begin
        if (evt.evt_ready) begin
          handshake  = 1'b1;
          grant_next = evt_id_q;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Press acceptance. A press on the button being handed off this very cycle
  // re-arms its pending flag instead of counting as an overflow.
  always_comb begin
    pend_next = pending;
    ovf_next  = overflow;
    reload    = '0;
    clr_hit   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      clr_hit[i] = handshake && (evt_id_q == ID_W'(i));
      if (clr_hit[i]) begin
        pend_next[i] = 1'b0;
      end
      if (btn_pulse[i] && (lock_cnt[i] == '0)) begin
        if (!pending[i] || clr_hit[i]) begin
          pend_next[i] = 1'b1;
          reload[i]    = 1'b1;
        end else begin
          ovf_next[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      evt_id_q   <= '0;
      last_grant <= GRANT_INIT;
      pending    <= '0;
      overflow   <= '0;
    end else begin
      evt_id_q   <= id_next;
      last_grant <= grant_next;
      pending    <= pend_next;
      overflow   <= ovf_next;
    end
  end

  // Lockout counters: reload wins over the decrement; saturate at zero.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < N_BTN; i++) begin
        lock_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (reload[i]) begin
          lock_cnt[i] <= LOCK_LOAD;
        end else if (lock_cnt[i] != '0) begin
          lock_cnt[i] <= lock_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;
  localparam int N_BTN = 4;
  localparam int ID_W  = 2;
  localparam int L     = 8;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             clear;
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] overflow;

  int total = 0;
  int bad   = 0;

  button_event_arbiter_if #(.ID_W(ID_W)) evt_if ();

  button_event_arbiter #(
    .N_BTN(N_BTN),
    .ID_W(ID_W),
    .LOCKOUT_CYCLES(L),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .clear(clear),
    .btn_pulse(btn),
    .evt(evt_if.master),
    .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: lockout tracked as "locked through cycle number",
  // arbitration as a plain offered/idle flag with a search loop.
  int          m_cyc;
  bit          m_valid;
  int          m_id;
  int          m_lg;
  bit [N_BTN-1:0] m_pend;
  bit [N_BTN-1:0] m_ovf;
  int          m_lock_until [N_BTN];

  always @(posedge clk or posedge clear) begin
    bit hs;
    bit busy;
    bit [N_BTN-1:0] old_p;
    bit [N_BTN-1:0] p;
    bit found;
    int t;
    if (clear) begin
      m_cyc   = 0;
      m_valid = 0;
      m_id    = 0;
      m_lg    = N_BTN - 1;
      m_pend  = '0;
      m_ovf   = '0;
      for (int i = 0; i < N_BTN; i++) m_lock_until[i] = -1;
    end else begin
      hs    = m_valid && evt_if.evt_ready;
      old_p = m_pend;
      p     = old_p;
      if (hs) p[m_id] = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        if (btn[i] && (m_cyc > m_lock_until[i])) begin
          busy = old_p[i] && !(hs && (m_id == i));
          if (!busy) begin
            p[i] = 1'b1;
            m_lock_until[i] = m_cyc + L;
          end else begin
            m_ovf[i] = 1'b1;
          end
        end
      end
      if (m_valid) begin
        if (evt_if.evt_ready) begin
          m_valid = 0;
          m_lg    = m_id;
        end
      end else if (old_p != '0) begin
        found = 0;
        for (int k = 1; k <= N_BTN; k++) begin
          t = (m_lg + k) % N_BTN;
          if (!found && old_p[t]) begin
            found = 1;
            m_id  = t;
          end
        end
        m_valid = 1;
      end
      m_pend = p;
      m_cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One clock: sample after the falling edge and compare DUT with the model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("model_valid", int'(evt_if.evt_valid), int'(m_valid));
    if (m_valid) chk("model_id", int'(evt_if.evt_id), m_id);
    chk("model_pending", int'(pending), int'(m_pend));
    chk("model_overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic do_reset();
    clear = 1'b1;
    btn = '0;
    evt_if.evt_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear = 1'b1;
    btn = '0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", int'(evt_if.evt_valid), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
    clear = 1'b0;

    // clear while an event is on offer
    btn = 4'b0110;
    tick();
    btn = '0;
    tick();
    chk("preclr_pending", int'(pending), 6);
    chk("preclr_valid", int'(evt_if.evt_valid), 1);
    chk("preclr_id", int'(evt_if.evt_id), 1);
    #2 clear = 1'b1;
    #1;
    chk("midclr_valid", int'(evt_if.evt_valid), 0);
    chk("midclr_pending", int'(pending), 0);
    chk("midclr_overflow", int'(overflow), 0);
    chk("midclr_id", int'(evt_if.evt_id), 0);
    @(negedge clk);
    clear = 1'b0;
    repeat (3) tick();
    chk("idle_valid", int'(evt_if.evt_valid), 0);

    // single press with ready held high
    do_reset();
    evt_if.evt_ready = 1'b1;
    btn = 4'b0100;
    tick();
    btn = '0;
    chk("single_pend", int'(pending), 4);
    chk("single_nov", int'(evt_if.evt_valid), 0);
    tick();
    chk("single_valid", int'(evt_if.evt_valid), 1);
    chk("single_id", int'(evt_if.evt_id), 2);
    tick();
    chk("single_done_valid", int'(evt_if.evt_valid), 0);
    chk("single_done_pend", int'(pending), 0);

    // round robin over all buttons, then a wrapped pair
    do_reset();
    evt_if.evt_ready = 1'b1;
    btn = 4'b1111;
    tick();
    btn = '0;
    chk("rr_pend", int'(pending), 15);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr_valid%0d", k), int'(evt_if.evt_valid), 1);
      chk($sformatf("rr_id%0d", k), int'(evt_if.evt_id), k);
      tick();
      chk($sformatf("rr_gap%0d", k), int'(evt_if.evt_valid), 0);
    end
    btn = 4'b1001;
    tick();
    btn = '0;
    tick();
    chk("rr2_id_a", int'(evt_if.evt_id), 0);
    tick();
    tick();
    chk("rr2_id_b", int'(evt_if.evt_id), 3);
    tick();
    chk("rr2_end", int'(evt_if.evt_valid), 0);

    // backpressure: offered event stays put while another press arrives
    do_reset();
    btn = 4'b0010;
    tick();
    btn = '0;
    tick();
    chk("bp_valid", int'(evt_if.evt_valid), 1);
    chk("bp_id", int'(evt_if.evt_id), 1);
    for (int c = 0; c < 20; c++) begin
      btn = (c == 5) ? 4'b1000 : 4'b0000;
      tick();
      chk("bp_hold_valid", int'(evt_if.evt_valid), 1);
      chk("bp_hold_id", int'(evt_if.evt_id), 1);
    end
    btn = '0;
    chk("bp_pend", int'(pending), 10);
    evt_if.evt_ready = 1'b1;
    tick();
    chk("bp_hs_valid", int'(evt_if.evt_valid), 0);
    tick();
    chk("bp_next_valid", int'(evt_if.evt_valid), 1);
    chk("bp_next_id", int'(evt_if.evt_id), 3);
    tick();
    chk("bp_end_pend", int'(pending), 0);

    // lockout and overflow on button 0
    do_reset();
    for (int e = 0; e < 12; e++) begin
      btn = (e == 0 || e == 4 || e == 9) ? 4'b0001 : 4'b0000;
      tick();
      if (e == 4) chk("lock_ovf_e4", int'(overflow[0]), 0);
      if (e == 9) chk("lock_ovf_e9", int'(overflow[0]), 1);
    end
    btn = '0;
    evt_if.evt_ready = 1'b1;
    repeat (4) tick();
    chk("lock_ovf_sticky", int'(overflow[0]), 1);
    chk("lock_pend_done", int'(pending), 0);
    do_reset();
    chk("lock_ovf_cleared", int'(overflow), 0);

    // re-press of the offered button on its handshake cycle
    do_reset();
    for (int e = 0; e < 10; e++) begin
      btn = (e == 0 || e == 9) ? 4'b0010 : 4'b0000;
      evt_if.evt_ready = (e == 9);
      tick();
      if (e == 1) begin
        chk("bnd_valid", int'(evt_if.evt_valid), 1);
        chk("bnd_id", int'(evt_if.evt_id), 1);
      end
    end
    btn = '0;
    chk("bnd_pend", int'(pending), 2);
    chk("bnd_ovf", int'(overflow), 0);
    chk("bnd_gap", int'(evt_if.evt_valid), 0);
    tick();
    chk("bnd_reoffer_valid", int'(evt_if.evt_valid), 1);
    chk("bnd_reoffer_id", int'(evt_if.evt_id), 1);
    tick();
    chk("bnd_end_pend", int'(pending), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
